mem_arbiter: RTL and testbench

//   Shares the single-port program/data memory (u0) between two requesters:

---
 rtl/proc_pkg.sv | 24 ++
 rtl/arb_prio2.sv | 60 ++++++
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the processor memory subsystem.
//   - Default widths for the program/data memory interface.
//   - Arbiter FSM state encoding and the grant owner encoding
//     (OWN_CPU = port 0, OWN_LDR = port 1), shared by mem_arbiter and arb_prio2.
package proc_pkg;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_LDR
  } arb_owner_t;

endpackage

// File: rtl/arb_prio2.sv
// Two-way fixed-priority pick with an anti-starvation override.
//   The CPU wins when both ports request, unless the loader has already been
//   passed over STARVE_MAX consecutive times, in which case the loader wins.
//   The starvation counter only moves on cycles where arbitration is enabled
//   (arbiter in IDLE).
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   arb_en        arbitration enabled this cycle (arbiter is idle)
//   cpu_req       CPU request
//   ldr_req       loader request
//   gnt_vld       a grant is made this cycle (combinational)
//   gnt_own       port granted this cycle (combinational, valid with gnt_vld)
module arb_prio2
  import proc_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       arb_en,
  input  logic       cpu_req,
  input  logic       ldr_req,
  output logic       gnt_vld,
  output arb_owner_t gnt_own
);

  localparam int            CW      = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;
  logic          ldr_wins;

  // Saturating increment; the counter is normally cleared by the loader grant
  // before it could pass CNT_MAX, the clamp just keeps it from wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  assign ldr_wins = ldr_req && (!cpu_req || (starve_cnt == CNT_MAX));

  always_comb begin
    gnt_vld = arb_en && (cpu_req || ldr_req);
    gnt_own = ldr_wins ? OWN_LDR : OWN_CPU;
  end

  // Counts CPU grants made while the loader is waiting; any idle cycle
  // without a loader request, or a loader grant, restarts the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (!ldr_req || ldr_wins) begin
        starve_cnt <= '0;
      end else if (gnt_vld) begin
        starve_cnt <= sat_inc(starve_cnt);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port program/data memory between the CPU core (port 0)
// and the loader/debug DMA (port 1). One access is in flight at a time:
//   IDLE -> ISSUE -> (read: WAIT x MEM_LAT) -> RESP -> IDLE
// The granted request (we/addr/wdata) is latched in IDLE, so requester inputs
// may change after the grant without affecting the access. Each port gets a
// one-cycle ack in RESP; read data is held in a per-port register that only
// changes when that port's own read completes.
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i      CPU request, held until cpu_ack_o
//   cpu_ack_o, cpu_rdata_o             CPU completion pulse and read data
//   ldr_req_i/we_i/addr_i/wdata_i      loader request, held until ldr_ack_o
//   ldr_ack_o, ldr_rdata_o             loader completion pulse and read data
//   mem_en_o/we_o/addr_o/wdata_o       memory command, one cycle per access,
//                                      all zero while mem_en_o is low
//   mem_rdata_i                        memory read data, MEM_LAT cycles after en
//   busy_o                             access in progress (state != IDLE)
//   owner_o                            current/last grantee (0=CPU, 1=loader)
module mem_arbiter
  import proc_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              ldr_req_i,
  input  logic              ldr_we_i,
  input  logic [ADDR_W-1:0] ldr_addr_i,
  input  logic [DATA_W-1:0] ldr_wdata_i,
  output logic              ldr_ack_o,
  output logic [DATA_W-1:0] ldr_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              owner_o
);

  // Latency counter is loaded with MEM_LAT-1 and counts down to zero.
  localparam int            LW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LW-1:0] LAT_LOAD = LW'(MEM_LAT - 1);

  arb_state_t        state;
  arb_owner_t        owner;
  logic              we_q;
  logic              mem_en_q;
  logic              cpu_ack_q;
  logic              ldr_ack_q;
  logic [LW-1:0]     lat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ldr_rdata_q;

  logic              arb_en;
  logic              gnt_vld;
  arb_owner_t        gnt_own;
  logic              sel_we;

  assign arb_en = (state == ST_IDLE);
  assign sel_we = (gnt_own == OWN_LDR) ? ldr_we_i : cpu_we_i;

  arb_prio2 #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .arb_en  (arb_en),
    .cpu_req (cpu_req_i),
    .ldr_req (ldr_req_i),
    .gnt_vld (gnt_vld),
    .gnt_own (gnt_own)
  );

  // Address and write data of the granted port. These are only observed
  // through the gated memory outputs, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (arb_en && gnt_vld) begin
      if (gnt_own == OWN_LDR) begin
        addr_q  <= ldr_addr_i;
        wdata_q <= ldr_wdata_i;
      end else begin
        addr_q  <= cpu_addr_i;
        wdata_q <= cpu_wdata_i;
      end
    end
  end

  // Access sequencer. mem_en_q and the acks are registered one state ahead,
  // so mem_en is high exactly in ISSUE and the ack exactly in RESP.
  // Reset drops everything at once, abandoning any access in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      owner       <= OWN_CPU;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      lat_cnt     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      mem_en_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      ldr_ack_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            owner    <= gnt_own;
            we_q     <= sel_we;
            mem_en_q <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (we_q) begin
            cpu_ack_q <= (owner == OWN_CPU);
            ldr_ack_q <= (owner == OWN_LDR);
            state     <= ST_RESP;
          end else begin
            lat_cnt <= LAT_LOAD;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == '0) begin
            // Read data lands in the owner's register only.
            if (owner == OWN_LDR) begin
              ldr_rdata_q <= mem_rdata_i;
              ldr_ack_q   <= 1'b1;
            end else begin
              cpu_rdata_q <= mem_rdata_i;
              cpu_ack_q   <= 1'b1;
            end
            state <= ST_RESP;
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_en_q & we_q;
  assign mem_addr_o  = mem_en_q ? addr_q  : '0;
  assign mem_wdata_o = mem_en_q ? wdata_q : '0;

  assign cpu_ack_o   = cpu_ack_q;
  assign ldr_ack_o   = ldr_ack_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign ldr_rdata_o = ldr_rdata_q;
  assign busy_o      = (state != ST_IDLE);
  assign owner_o     = (owner == OWN_LDR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a MEM_LAT=1 instance driven through a completion
// scoreboard, plus a MEM_LAT=3 instance for latency and address-latching.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  // MEM_LAT = 1 instance
  logic       cpu_req, cpu_we, cpu_ack;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       ldr_req, ldr_we, ldr_ack;
  logic [7:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic       mem_en, mem_we, busy, owner;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  // MEM_LAT = 3 instance
  logic       cpu_req3, cpu_we3, cpu_ack3;
  logic [7:0] cpu_addr3, cpu_wdata3, cpu_rdata3;
  logic       ldr_req3, ldr_we3, ldr_ack3;
  logic [7:0] ldr_addr3, ldr_wdata3, ldr_rdata3;
  logic       mem_en3, mem_we3, busy3, owner3;
  logic [7:0] mem_addr3, mem_wdata3, mem_rdata3;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
    .ldr_req_i(ldr_req), .ldr_we_i(ldr_we), .ldr_addr_i(ldr_addr), .ldr_wdata_i(ldr_wdata),
    .ldr_ack_o(ldr_ack), .ldr_rdata_o(ldr_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .busy_o(busy), .owner_o(owner)
  );

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req3), .cpu_we_i(cpu_we3), .cpu_addr_i(cpu_addr3), .cpu_wdata_i(cpu_wdata3),
    .cpu_ack_o(cpu_ack3), .cpu_rdata_o(cpu_rdata3),
    .ldr_req_i(ldr_req3), .ldr_we_i(ldr_we3), .ldr_addr_i(ldr_addr3), .ldr_wdata_i(ldr_wdata3),
    .ldr_ack_o(ldr_ack3), .ldr_rdata_o(ldr_rdata3),
    .mem_en_o(mem_en3), .mem_we_o(mem_we3), .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3),
    .mem_rdata_i(mem_rdata3), .busy_o(busy3), .owner_o(owner3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models with a preload port used while the arbiters are idle.
  logic       pl_we;
  logic [7:0] pl_addr, pl_data;
  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  logic [7:0] rp1;
  logic [7:0] rp3 [3];

  always @(posedge clk) begin
    if (pl_we) mem1[pl_addr] <= pl_data;
    else if (mem_en && mem_we) mem1[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) rp1 <= mem1[mem_addr];
  end
  assign mem_rdata = rp1;

  always @(posedge clk) begin
    if (pl_we) mem3[pl_addr] <= pl_data;
    else if (mem_en3 && mem_we3) mem3[mem_addr3] <= mem_wdata3;
    if (mem_en3 && !mem_we3) rp3[0] <= mem3[mem_addr3];
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign mem_rdata3 = rp3[2];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard of expected completions on the MEM_LAT=1 instance, in order.
  typedef struct {
    logic       own;   // 0 = CPU, 1 = loader
    logic       rd;
    logic [7:0] data;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;

  task automatic sb_push(input logic own, input logic rd, input logic [7:0] data);
    exp_t e;
    e.own  = own;
    e.rd   = rd;
    e.data = data;
    sb.push_back(e);
  endtask

  int cyc = 0;
  int en_cnt1 = 0, en_cnt3 = 0;
  int cpu_acks = 0, ldr_acks = 0;
  int cpu_ack_cyc = 0, ldr_ack_cyc = 0;
  int gate_err = 0;
  logic [7:0] en_addr3;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_en) en_cnt1++;
      if (mem_en3) begin en_cnt3++; en_addr3 = mem_addr3; end
      if (!mem_en && (mem_we || mem_addr != 8'h00 || mem_wdata != 8'h00)) gate_err++;
      if (!mem_en3 && (mem_we3 || mem_addr3 != 8'h00 || mem_wdata3 != 8'h00)) gate_err++;
      if (cpu_ack || ldr_ack) begin
        check_eq("single_ack", 32'(cpu_ack & ldr_ack), 0);
        check_eq("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check_eq("grant_owner", 32'(ldr_ack), 32'(mon_e.own));
          check_eq("owner_o", 32'(owner), 32'(mon_e.own));
          if (mon_e.rd)
            check_eq(mon_e.own ? "ldr_rdata" : "cpu_rdata",
                     32'(mon_e.own ? ldr_rdata : cpu_rdata), 32'(mon_e.data));
        end
        if (cpu_ack) begin cpu_acks++; cpu_ack_cyc = cyc; end
        if (ldr_ack) begin ldr_acks++; ldr_ack_cyc = cyc; end
      end
    end
  end

  // One access on a port of the MEM_LAT=1 instance. lat = clock edges from
  // driving the request to seeing the ack. With last=0 the request stays high
  // so the next call chains a back-to-back access.
  task automatic cpu_op(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                        input logic last, output int lat);
    int n = 0;
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!cpu_ack && n < 40);
    if (!cpu_ack) check_eq("cpu_ack_timeout", 0, 1);
    lat = n;
    if (last) begin @(posedge clk); #1; cpu_req = 1'b0; end
  endtask

  task automatic ldr_op(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                        input logic last, output int lat);
    int n = 0;
    ldr_we = we; ldr_addr = addr; ldr_wdata = wd; ldr_req = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!ldr_ack && n < 40);
    if (!ldr_ack) check_eq("ldr_ack_timeout", 0, 1);
    lat = n;
    if (last) begin @(posedge clk); #1; ldr_req = 1'b0; end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_we = 1'b1;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  int latc, latl, base_en, base_l, n3;

  initial begin
    rst = 1'b1; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
    cpu_req3 = 0; cpu_we3 = 0; cpu_addr3 = '0; cpu_wdata3 = '0;
    ldr_req3 = 0; ldr_we3 = 0; ldr_addr3 = '0; ldr_wdata3 = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check_eq("rst_mem_en", 32'(mem_en), 0);
    check_eq("rst_mem_addr", 32'(mem_addr), 0);
    check_eq("rst_cpu_ack", 32'(cpu_ack), 0);
    check_eq("rst_ldr_ack", 32'(ldr_ack), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_owner", 32'(owner), 0);
    check_eq("rst_cpu_rdata", 32'(cpu_rdata), 0);
    check_eq("rst_ldr_rdata", 32'(ldr_rdata), 0);

    preload(8'h10, 8'hA5);
    preload(8'h33, 8'h5A);
    preload(8'h44, 8'h11);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: single CPU read
    base_en = en_cnt1; base_l = ldr_acks;
    sb_push(1'b0, 1'b1, 8'hA5);
    cpu_op(1'b0, 8'h10, 8'h00, 1'b1, latc);
    check_eq("t1_read_latency", 32'(latc), 3);
    check_eq("t1_mem_en_cycles", 32'(en_cnt1 - base_en), 1);
    check_eq("t1_no_ldr_ack", 32'(ldr_acks - base_l), 0);

    // 2: loader write burst, acks 3 cycles apart, then CPU readback
    for (int i = 0; i < 16; i++) begin
      sb_push(1'b1, 1'b0, 8'h00);
      ldr_op(1'b1, 8'(i), 8'(i + 1), (i == 15), latl);
      check_eq("t2_burst_gap", 32'(latl), (i == 0) ? 2 : 3);
    end
    sb_push(1'b0, 1'b1, 8'h06);
    cpu_op(1'b0, 8'h05, 8'h00, 1'b1, latc);

    // 3: both request continuously -> C,C,C,C,L,C,C,C,C,L
    for (int k = 0; k < 10; k++) sb_push((k == 4 || k == 9), 1'b0, 8'h00);
    fork
      begin
        for (int i = 0; i < 8; i++) cpu_op(1'b1, 8'(8'h80 + i), 8'(i), (i == 7), latc);
      end
      begin
        for (int j = 0; j < 2; j++) ldr_op(1'b1, 8'(8'h90 + j), 8'(8'hF0 + j), (j == 1), latl);
      end
    join

    // 4: simultaneous single writes, CPU first, loader 3 cycles later
    sb_push(1'b0, 1'b0, 8'h00);
    sb_push(1'b1, 1'b0, 8'h00);
    fork
      cpu_op(1'b1, 8'h20, 8'hC4, 1'b1, latc);
      ldr_op(1'b1, 8'h21, 8'h4D, 1'b1, latl);
    join
    check_eq("t4_ldr_after_cpu", 32'(ldr_ack_cyc - cpu_ack_cyc), 3);
    sb_push(1'b0, 1'b1, 8'hC4);
    cpu_op(1'b0, 8'h20, 8'h00, 1'b1, latc);
    sb_push(1'b1, 1'b1, 8'h4D);
    ldr_op(1'b0, 8'h21, 8'h00, 1'b1, latl);
    check_eq("t4_cpu_rdata_kept", 32'(cpu_rdata), 'hC4);
    check_eq("t3_mem_0x87", 32'(mem1[8'h87]), 'h07);

    // 5: reset during WAIT of a CPU read
    cpu_we = 1'b0; cpu_addr = 8'h44; cpu_req = 1'b1;
    @(posedge clk); #1;
    check_eq("t5_issue_en", 32'(mem_en), 1);
    @(posedge clk); #1;
    check_eq("t5_wait_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_mem_en", 32'(mem_en), 0);
    check_eq("t5_rst_ack", 32'(cpu_ack | ldr_ack), 0);
    check_eq("t5_rst_busy", 32'(busy), 0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("t5_rdata_cleared", 32'(cpu_rdata), 0);
    repeat (4) @(posedge clk);
    #1;
    sb_push(1'b0, 1'b1, 8'hA5);
    cpu_op(1'b0, 8'h10, 8'h00, 1'b1, latc);
    check_eq("t5_fresh_latency", 32'(latc), 3);

    // 6: MEM_LAT=3, address changed after grant
    base_en = en_cnt3;
    cpu_we3 = 1'b0; cpu_addr3 = 8'h33; cpu_req3 = 1'b1;
    @(posedge clk); #1;
    n3 = 1;
    cpu_addr3 = 8'h44;
    while (!cpu_ack3 && n3 < 20) begin @(posedge clk); #1; n3++; end
    check_eq("t6_ack_seen", 32'(cpu_ack3), 1);
    check_eq("t6_read_latency", 32'(n3), 5);
    check_eq("t6_rdata", 32'(cpu_rdata3), 'h5A);
    check_eq("t6_mem_addr", 32'(en_addr3), 'h33);
    check_eq("t6_mem_en_cycles", 32'(en_cnt3 - base_en), 1);
    @(posedge clk); #1;
    cpu_req3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check_eq("mem_outputs_gated", 32'(gate_err), 0);
    check_eq("sb_drained", 32'(sb.size()), 0);
    check_eq("ldr3_no_ack", 32'(ldr_ack3), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

endmodule
